// File: rtl/rsa_uart_bridge_if.sv
// Avalon-MM bus between the RSA bridge (master) and the UART core (slave).
// A transfer holds strobe/address/writedata while waitrequest=1, completes on the first edge with
// waitrequest=0, and the strobe is then low for one cycle before the next transfer.
interface rsa_uart_bridge_if;
   logic [4:0]  avm_address;
   logic        avm_read;
   logic [31:0] avm_readdata;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic        avm_waitrequest;

   modport master (
      output avm_address, avm_read, avm_write, avm_writedata,
      input  avm_readdata, avm_waitrequest
   );

   modport slave (
      input  avm_address, avm_read, avm_write, avm_writedata,
      output avm_readdata, avm_waitrequest
   );
endinterface

// File: rtl/rsa_uart_bridge.sv
// UART <-> RSA-256 core bridge: receives N, d and ciphertext bytes, runs the core, sends plaintext.
// Optional macro RSA_BRIDGE_DEBUG_EN puts a block counter, state and byte count on debug_num.
module rsa_uart_bridge #(
   parameter int         KEY_BYTES   = 32,
   parameter int         OUT_BYTES   = 31,
   parameter logic [4:0] RX_BASE     = 5'd0,
   parameter logic [4:0] TX_BASE     = 5'd4,
   parameter logic [4:0] STATUS_BASE = 5'd8,
   parameter int         RRDY_BIT    = 7,
   parameter int         TRDY_BIT    = 6
) (
   input  logic                     avm_clk,
   input  logic                     avm_rst,
   rsa_uart_bridge_if.master        avm,
   output logic                     o_core_start,
   output logic [255:0]             o_core_a,
   output logic [255:0]             o_core_e,
   output logic [255:0]             o_core_n,
   input  logic [255:0]             i_core_a_pow_e,
   input  logic                     i_core_finished,
   output logic [31:0]              debug_num,
   output logic [2:0]               dbg_state_o
);

   typedef enum logic [2:0] {
      S_GET_N   = 3'd0,
      S_GET_D   = 3'd1,
      S_GET_ENC = 3'd2,
      S_START   = 3'd3,
      S_WAIT    = 3'd4,
      S_SEND    = 3'd5
   } state_e;

   typedef enum logic {
      P_QUERY = 1'b0,
      P_DATA  = 1'b1
   } phase_e;

   localparam logic [5:0] RX_LAST = 6'(KEY_BYTES - 1);
   localparam logic [5:0] TX_LAST = 6'(OUT_BYTES - 1);

   state_e        state_q, state_d;
   phase_e        phase_q, phase_d;
   logic [255:0]  n_q, n_d;
   logic [255:0]  e_q, e_d;
   logic [255:0]  a_q, a_d;
   logic [247:0]  shift_q, shift_d;
   logic [5:0]    cnt_q, cnt_d;
   logic          read_q, read_d;
   logic          write_q, write_d;
   logic [4:0]    addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;

   logic          bus_idle;
   logic          xfer_done;
   logic [7:0]    rx_byte;
   logic          unused_bits;

   assign bus_idle  = !read_q && !write_q;
   assign xfer_done = (read_q || write_q) && !avm.avm_waitrequest;
   assign rx_byte   = avm.avm_readdata[7:0];

   // Upper readdata bits and the result MSB byte never matter to this bridge.
   assign unused_bits = ^{avm.avm_readdata[31:8], i_core_a_pow_e[255:248]};

   always_ff @(posedge avm_clk) begin
      if (avm_rst) begin
         state_q <= S_GET_N;
         phase_q <= P_QUERY;
         n_q     <= '0;
         e_q     <= '0;
         a_q     <= '0;
         shift_q <= '0;
         cnt_q   <= '0;
         read_q  <= 1'b0;
         write_q <= 1'b0;
         addr_q  <= STATUS_BASE;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         n_q     <= n_d;
         e_q     <= e_d;
         a_q     <= a_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         read_q  <= read_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      n_d     = n_q;
      e_d     = e_q;
      a_d     = a_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      read_d  = read_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;

      case (state_q)
         S_GET_N, S_GET_D, S_GET_ENC: begin
            // An idle bus here is always the one-cycle gap after the previous transfer.
            if (bus_idle) begin
               read_d = 1'b1;
               addr_d = (phase_q == P_QUERY) ? STATUS_BASE : RX_BASE;
            end else if (xfer_done) begin
               read_d = 1'b0;
               if (phase_q == P_QUERY) begin
                  if (avm.avm_readdata[RRDY_BIT]) begin
                     phase_d = P_DATA;
                  end
               end else begin
                  phase_d = P_QUERY;
                  case (state_q)
                     S_GET_N: n_d = {n_q[247:0], rx_byte};
                     S_GET_D: e_d = {e_q[247:0], rx_byte};
                     default: a_d = {a_q[247:0], rx_byte};
                  endcase
                  if (cnt_q == RX_LAST) begin
                     cnt_d = '0;
                     case (state_q)
                        S_GET_N: state_d = S_GET_D;
                        S_GET_D: state_d = S_GET_ENC;
                        default: state_d = S_START;
                     endcase
                  end else begin
                     cnt_d = cnt_q + 6'd1;
                  end
               end
            end
         end

         S_START: begin
            state_d = S_WAIT;
         end

         S_WAIT: begin
            if (i_core_finished) begin
               shift_d = i_core_a_pow_e[247:0];
               state_d = S_SEND;
               phase_d = P_QUERY;
            end
         end

         S_SEND: begin
            if (bus_idle) begin
               if (phase_q == P_QUERY) begin
                  read_d = 1'b1;
                  addr_d = STATUS_BASE;
               end else begin
                  write_d = 1'b1;
                  addr_d  = TX_BASE;
               end
            end else if (xfer_done) begin
               read_d  = 1'b0;
               write_d = 1'b0;
               if (phase_q == P_QUERY) begin
                  if (avm.avm_readdata[TRDY_BIT]) begin
                     phase_d = P_DATA;
                     wdata_d = {24'b0, shift_q[247:240]};
                  end
               end else begin
                  phase_d = P_QUERY;
                  shift_d = {shift_q[239:0], 8'h00};
                  if (cnt_q == TX_LAST) begin
                     cnt_d   = '0;
                     state_d = S_GET_ENC;
                  end else begin
                     cnt_d = cnt_q + 6'd1;
                  end
               end
            end
         end

         default: begin
            state_d = S_GET_N;
            phase_d = P_QUERY;
            read_d  = 1'b0;
            write_d = 1'b0;
         end
      endcase
   end

   assign avm.avm_address   = addr_q;
   assign avm.avm_read      = read_q;
   assign avm.avm_write     = write_q;
   assign avm.avm_writedata = wdata_q;

   assign o_core_start = (state_q == S_START);
   assign o_core_a     = a_q;
   assign o_core_e     = e_q;
   assign o_core_n     = n_q;
   assign dbg_state_o  = state_q;

`ifdef RSA_BRIDGE_DEBUG_EN
   logic [15:0] block_cnt_q, block_cnt_d;

   always_comb begin
      block_cnt_d = block_cnt_q;
      if (state_q == S_SEND && state_d == S_GET_ENC) begin
         block_cnt_d = block_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge avm_clk) begin
      if (avm_rst) begin
         block_cnt_q <= '0;
      end else begin
         block_cnt_q <= block_cnt_d;
      end
   end

   // Hex digits: BBBB 0 S CC (block count, spare zero digit, state, byte count).
   assign debug_num = {block_cnt_q, 4'h0, 1'b0, state_q, 2'b0, cnt_q};
`else
   assign debug_num = 32'h0;
`endif

endmodule

// File: tb/tb_rsa_uart_bridge.sv
// Directed bench for rsa_uart_bridge: UART slave model on the Avalon bus, write scoreboard,
// receive/send/waitrequest/reset scenarios with hand-computed expectations.
module tb_rsa_uart_bridge;

   localparam logic [2:0] S_GET_N   = 3'd0;
   localparam logic [2:0] S_GET_D   = 3'd1;
   localparam logic [2:0] S_GET_ENC = 3'd2;
   localparam logic [2:0] S_WAIT    = 3'd4;

   localparam logic [255:0] N_VAL = 256'hCA3586E7_897F5C4B_1D2E3F40_51627384_95A6B7C8_D9EAFB0C_1D2E3F50_6172839B;
   localparam logic [255:0] D_VAL = 256'h01234567_89ABCDEF_FEDCBA98_76543210_11112222_33334444_55556666_77778889;
   localparam logic [255:0] A1    = 256'h01020304_05060708_090A0B0C_0D0E0F10_11121314_15161718_191A1B1C_1D1E1F20;
   localparam logic [255:0] A2    = 256'h201F1E1D_1C1B1A19_18171615_14131211_100F0E0D_0C0B0A09_08070605_04030201;
   localparam logic [255:0] D_TOP10 = 256'h0123_4567_89AB_CDEF_FEDC;

`ifdef RSA_BRIDGE_DEBUG_EN
   localparam logic [31:0] DBG_BLK1 = 32'h0001_0200;
   localparam logic [31:0] DBG_BLK2 = 32'h0002_0200;
`else
   localparam logic [31:0] DBG_BLK1 = 32'h0;
   localparam logic [31:0] DBG_BLK2 = 32'h0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rsa_uart_bridge_if bus ();

   logic          core_start;
   logic [255:0]  core_a, core_e, core_n;
   logic [255:0]  pow_e;
   logic          finished;
   logic [31:0]   debug_num;
   logic [2:0]    dbg_state;

   rsa_uart_bridge dut (
      .avm_clk         (clk),
      .avm_rst         (rst),
      .avm             (bus.master),
      .o_core_start    (core_start),
      .o_core_a        (core_a),
      .o_core_e        (core_e),
      .o_core_n        (core_n),
      .i_core_a_pow_e  (pow_e),
      .i_core_finished (finished),
      .debug_num       (debug_num),
      .dbg_state_o     (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] exp_q[$];
   logic [7:0]  rx_q[$];

   int status_rd, rx_rd, tx_wr, start_cnt;
   int overlap, gap_viol, stable_viol, rx_early, tx_early, tx_extra, addr_bad;
   int wait_cycles, rrdy_delay, poll_left, wcnt;
   bit trdy_toggle, tog, last_rrdy, last_trdy, stalled, after_done;
   logic        s_rd, s_wr;
   logic [4:0]  s_addr;
   logic [31:0] s_wd, sl_valid;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] slave_rdata(input logic [4:0] addr);
      logic [31:0] d;
      d = $urandom;
      if (addr == 5'd8) begin
         d[7] = (poll_left == 0) && (rx_q.size() > 0);
         d[6] = trdy_toggle ? tog : 1'b1;
      end else if (addr == 5'd0) begin
         d[7:0] = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
      end
      return d;
   endfunction

   // ---------------- UART slave model + bus monitor (runs mid-cycle) ----------------
   always @(negedge clk) begin
      if (rst) begin
         wcnt = 0;
         stalled = 1'b0;
         after_done = 1'b0;
         bus.avm_waitrequest = 1'b0;
         bus.avm_readdata = '0;
      end else begin
         if (bus.avm_read && bus.avm_write) overlap++;
         if (after_done && (bus.avm_read || bus.avm_write)) gap_viol++;
         if (stalled && (bus.avm_read !== s_rd || bus.avm_write !== s_wr ||
                         bus.avm_address !== s_addr || bus.avm_writedata !== s_wd)) stable_viol++;
         after_done = 1'b0;
         stalled = 1'b0;
         if (bus.avm_read || bus.avm_write) begin
            sl_valid = slave_rdata(bus.avm_address);
            if (wcnt < wait_cycles) begin
               bus.avm_waitrequest = 1'b1;
               bus.avm_readdata = ~sl_valid;
               wcnt++;
               stalled = 1'b1;
               s_rd = bus.avm_read;
               s_wr = bus.avm_write;
               s_addr = bus.avm_address;
               s_wd = bus.avm_writedata;
            end else begin
               bus.avm_waitrequest = 1'b0;
               bus.avm_readdata = sl_valid;
               wcnt = 0;
               after_done = 1'b1;
               if (bus.avm_read) begin
                  if (bus.avm_address == 5'd8) begin
                     status_rd++;
                     last_rrdy = sl_valid[7];
                     last_trdy = sl_valid[6];
                     if (poll_left > 0 && rx_q.size() > 0) poll_left--;
                     if (trdy_toggle) tog = ~tog;
                  end else if (bus.avm_address == 5'd0) begin
                     rx_rd++;
                     if (!last_rrdy) rx_early++;
                     if (rx_q.size() > 0) void'(rx_q.pop_front());
                     poll_left = rrdy_delay;
                     last_rrdy = 1'b0;
                  end else begin
                     addr_bad++;
                  end
               end else begin
                  tx_wr++;
                  if (bus.avm_address != 5'd4) addr_bad++;
                  if (!last_trdy) tx_early++;
                  if (exp_q.size() > 0) check("tx_byte", 256'(bus.avm_writedata), 256'(exp_q.pop_front()));
                  else tx_extra++;
                  last_trdy = 1'b0;
               end
            end
         end else begin
            bus.avm_waitrequest = 1'b0;
            bus.avm_readdata = '0;
         end
      end
      if (core_start) start_cnt++;
   end

   // ---------------- driver tasks ----------------
   task automatic sync();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_counts();
      status_rd = 0; rx_rd = 0; tx_wr = 0; start_cnt = 0;
   endtask

   task automatic push_bytes(input logic [255:0] v, input int nb);
      for (int i = 0; i < nb; i++) rx_q.push_back(v[255-8*i -: 8]);
   endtask

   task automatic pulse_finished(input logic [255:0] res);
      sync();
      pow_e = res;
      finished = 1'b1;
      sync();
      finished = 1'b0;
   endtask

   task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
      for (int i = 0; i < budget; i++) begin
         sync();
         if (dbg_state == target) break;
      end
      check(tag, 256'(dbg_state), 256'(target));
   endtask

   task automatic wait_rx(input int n, input int budget, input string tag);
      for (int i = 0; i < budget; i++) begin
         sync();
         if (rx_rd >= n) break;
      end
      check(tag, 256'(rx_rd), 256'(n));
   endtask

   task automatic load_send(input logic [7:0] msb, input logic [7:0] first, output logic [255:0] res);
      res = '0;
      res[255:248] = msb;
      for (int i = 0; i < 31; i++) begin
         res[247-8*i -: 8] = first + 8'(i);
         exp_q.push_back({24'h0, first + 8'(i)});
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   logic [255:0] res;
   bit found;

   initial begin
      rst = 1'b1; finished = 1'b0; pow_e = '0;
      bus.avm_waitrequest = 1'b0; bus.avm_readdata = '0;
      wait_cycles = 0; rrdy_delay = 0; poll_left = 0; wcnt = 0;
      trdy_toggle = 1'b0; tog = 1'b0; last_rrdy = 1'b0; last_trdy = 1'b0;
      overlap = 0; gap_viol = 0; stable_viol = 0; rx_early = 0; tx_early = 0; tx_extra = 0; addr_bad = 0;
      clear_counts();
      repeat (3) sync();

      check("rst_read", 256'(bus.avm_read), 256'(0));
      check("rst_write", 256'(bus.avm_write), 256'(0));
      check("rst_addr", 256'(bus.avm_address), 256'(8));
      check("rst_wdata", 256'(bus.avm_writedata), 256'(0));
      check("rst_start", 256'(core_start), 256'(0));
      check("rst_debug", 256'(debug_num), 256'(0));
      check("rst_state", 256'(dbg_state), 256'(S_GET_N));
      check("rst_n", core_n, 256'(0));
      rst = 1'b0;

      // Block 1: N, d, ciphertext with RRDY always set
      clear_counts();
      push_bytes(N_VAL, 32);
      push_bytes(D_VAL, 32);
      push_bytes(A1, 32);
      wait_state(S_WAIT, 3000, "blk1_reach_wait");
      repeat (3) sync();
      check("blk1_n", core_n, N_VAL);
      check("blk1_e", core_e, D_VAL);
      check("blk1_a", core_a, A1);
      check("blk1_reads", 256'(status_rd + rx_rd), 256'(192));
      check("blk1_rx_reads", 256'(rx_rd), 256'(96));
      check("blk1_start_pulses", 256'(start_cnt), 256'(1));

      // Send 1: TRDY toggles 0,1,0,1...
      clear_counts();
      trdy_toggle = 1'b1; tog = 1'b0;
      load_send(8'h00, 8'h41, res);
      pulse_finished(res);
      wait_state(S_GET_ENC, 3000, "send1_back_to_enc");
      check("send1_writes", 256'(tx_wr), 256'(31));
      check("send1_status_reads", 256'(status_rd), 256'(62));
      check("send1_exp_left", 256'(exp_q.size()), 256'(0));
      check("send1_n_stable", core_n, N_VAL);
      check("send1_a_stable", core_a, A1);
      check("send1_debug", 256'(debug_num), 256'(DBG_BLK1));

      // A finished pulse outside S_WAIT must be ignored
      pulse_finished({256{1'b1}});
      repeat (5) sync();
      check("stray_finish_state", 256'(dbg_state), 256'(S_GET_ENC));
      check("stray_finish_writes", 256'(tx_wr), 256'(31));

      // Block 2: ciphertext only, 5 not-ready polls before every byte
      trdy_toggle = 1'b0;
      rrdy_delay = 5; poll_left = 5;
      clear_counts();
      push_bytes(A2, 32);
      wait_state(S_WAIT, 8000, "blk2_reach_wait");
      repeat (3) sync();
      check("blk2_a", core_a, A2);
      check("blk2_n_kept", core_n, N_VAL);
      check("blk2_e_kept", core_e, D_VAL);
      check("blk2_rx_reads", 256'(rx_rd), 256'(32));
      check("blk2_status_reads", 256'(status_rd), 256'(192));
      check("blk2_start_pulses", 256'(start_cnt), 256'(1));

      // Send 2: MSB byte of result must not be sent
      rrdy_delay = 0; poll_left = 0;
      clear_counts();
      load_send(8'hFF, 8'hA0, res);
      pulse_finished(res);
      wait_state(S_GET_ENC, 3000, "send2_back_to_enc");
      check("send2_writes", 256'(tx_wr), 256'(31));
      check("send2_status_reads", 256'(status_rd), 256'(31));
      check("send2_debug", 256'(debug_num), 256'(DBG_BLK2));

      // Restart with 3-cycle waitrequest, then reset mid S_GET_D during a stalled transfer
      rst = 1'b1;
      repeat (2) sync();
      rst = 1'b0;
      wait_cycles = 3;
      clear_counts();
      push_bytes(N_VAL, 32);
      push_bytes(D_VAL, 10);
      wait_rx(42, 4000, "ws_rx_reads");
      check("ws_n", core_n, N_VAL);
      check("ws_e_partial", core_e, D_TOP10);
      check("ws_state", 256'(dbg_state), 256'(S_GET_D));
      found = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         #1;
         if (bus.avm_read && bus.avm_waitrequest) begin
            found = 1'b1;
            break;
         end
      end
      check("ws_stall_seen", 256'(found), 256'(1));
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_read", 256'(bus.avm_read), 256'(0));
      check("mid_rst_write", 256'(bus.avm_write), 256'(0));
      check("mid_rst_state", 256'(dbg_state), 256'(S_GET_N));
      check("mid_rst_n", core_n, 256'(0));
      check("mid_rst_e", core_e, 256'(0));
      check("mid_rst_a", core_a, 256'(0));
      check("mid_rst_debug", 256'(debug_num), 256'(0));
      repeat (2) sync();
      rst = 1'b0;
      repeat (2) sync();

      check("bus_rw_overlap", 256'(overlap), 256'(0));
      check("bus_gap", 256'(gap_viol), 256'(0));
      check("bus_stable", 256'(stable_viol), 256'(0));
      check("rx_before_rrdy", 256'(rx_early), 256'(0));
      check("tx_before_trdy", 256'(tx_early), 256'(0));
      check("tx_unexpected", 256'(tx_extra), 256'(0));
      check("bad_address", 256'(addr_bad), 256'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
